// File: rtl/stream_demux.sv
// 1-to-2 valid/ready stream demultiplexer.
// Each beat is steered by in_select into one of two independent lane FIFOs.
module stream_demux_lane #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             pop;

  assign full       = (cnt == CW'(DEPTH));
  assign head_valid = (cnt != '0);
  assign head_data  = mem[rd_ptr];
  assign count      = cnt;
  assign pop        = head_valid & pop_ready;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

module stream_demux #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_select,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out0_data,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [WIDTH-1:0]       out1_data,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [$clog2(DEPTH):0] count0,
  output logic [$clog2(DEPTH):0] count1
);

  logic full0;
  logic full1;
  logic push0;
  logic push1;

  // Depends only on select and lane state, never on valid or out readies.
  assign in_ready = in_select ? ~full1 : ~full0;
  assign push0    = in_valid & in_ready & ~in_select;
  assign push1    = in_valid & in_ready & in_select;

  stream_demux_lane #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lane0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push0),
    .push_data  (in_data),
    .full       (full0),
    .pop_ready  (out0_ready),
    .head_data  (out0_data),
    .head_valid (out0_valid),
    .count      (count0)
  );

  stream_demux_lane #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lane1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push1),
    .push_data  (in_data),
    .full       (full1),
    .pop_ready  (out1_ready),
    .head_data  (out1_data),
    .head_valid (out1_valid),
    .count      (count1)
  );

endmodule
